// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
// Shares the single RAM data port between the processor and NUM_REQ IO-side
// requesters. The CPU always wins the port unless an IO access has already
// lost MAX_STALL consecutive cycles; then the CPU is stalled for one cycle
// so the IO access can go through. IO requesters are served round-robin.

module dmem_port_arbiter #(
  parameter int NUM_REQ   = 5,
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 32,
  parameter int MAX_STALL = 8
) (
  input  logic                        clock,
  input  logic                        reset,

  input  logic                        cpu_req,
  input  logic                        cpu_wren,
  input  logic [ADDR_W-1:0]           cpu_addr,
  input  logic [DATA_W-1:0]           cpu_data,
  output logic [DATA_W-1:0]           cpu_q,
  output logic                        cpu_stall,

  input  logic [NUM_REQ-1:0]          io_req,
  input  logic [NUM_REQ-1:0]          io_wren,
  input  logic [NUM_REQ*ADDR_W-1:0]   io_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   io_data,
  output logic [NUM_REQ-1:0]          io_gnt,
  output logic [NUM_REQ-1:0]          io_ack,
  output logic [DATA_W-1:0]           io_q,

  output logic                        ram_wEn,
  output logic [ADDR_W-1:0]           ram_addr,
  output logic [DATA_W-1:0]           ram_dataIn,
  input  logic [DATA_W-1:0]           ram_dataOut
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int SUM_W = IDX_W + 1;
  localparam logic [SUM_W-1:0]   NUM_REQ_S   = SUM_W'(NUM_REQ);
  localparam logic [7:0]         MAX_STALL_C = 8'(MAX_STALL);
  localparam logic [NUM_REQ-1:0] GNT_ONE     = NUM_REQ'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t              state;
  logic [IDX_W-1:0]    last_ptr;
  logic [IDX_W-1:0]    gnt_idx;
  logic [7:0]          stall_cnt;
  logic                lat_wren;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_data;

  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  logic [SUM_W-1:0]     rot_base;
  logic [SUM_W-1:0]     pick_off;
  logic [SUM_W-1:0]     pick_sum;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_valid;

  logic                 sel_wren;
  logic [ADDR_W-1:0]    sel_addr;
  logic [DATA_W-1:0]    sel_data;

  logic                 in_issue;
  logic                 force_io;
  logic                 io_owns;

  // Rotate the request vector so bit 0 is the requester just after last_ptr.
  // rot_base may equal NUM_REQ, which simply wraps back to requester 0.
  assign rot_base = {1'b0, last_ptr} + SUM_W'(1);
  assign req_dbl  = {io_req, io_req};
  assign req_rot  = NUM_REQ'(req_dbl >> rot_base);

  // Round-robin pick: first set bit in rotated order, mapped back to an index.
  always_comb begin
    pick_valid = 1'b0;
    pick_off   = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (req_rot[j]) begin
        pick_valid = 1'b1;
        pick_off   = SUM_W'(j);
      end
    end
    pick_sum = rot_base + pick_off;
    if (pick_sum >= NUM_REQ_S) begin
      pick_sum = pick_sum - NUM_REQ_S;
    end
    pick_idx = pick_sum[IDX_W-1:0];
  end

  // Select the picked requester's access fields for latching.
  always_comb begin
    sel_wren = 1'b0;
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == IDX_W'(i)) begin
        sel_wren = io_wren[i];
        sel_addr = io_addr[i*ADDR_W +: ADDR_W];
        sel_data = io_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Port ownership: IO only while issuing and either the CPU is idle or the
  // starved IO access is being forced through.
  assign in_issue  = (state == ISSUE);
  assign force_io  = (stall_cnt == MAX_STALL_C);
  assign io_owns   = in_issue & (~cpu_req | force_io);
  assign cpu_stall = in_issue & force_io & cpu_req;

  assign ram_wEn    = io_owns ? lat_wren : (cpu_req & cpu_wren);
  assign ram_addr   = io_owns ? lat_addr : cpu_addr;
  assign ram_dataIn = io_owns ? lat_data : cpu_data;
  assign cpu_q      = ram_dataOut;

  // Arbiter FSM: grant in IDLE, wait for the port in ISSUE, ack in RESP.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      last_ptr  <= IDX_W'(NUM_REQ - 1);
      gnt_idx   <= '0;
      stall_cnt <= '0;
      lat_wren  <= 1'b0;
      lat_addr  <= '0;
      lat_data  <= '0;
      io_gnt    <= '0;
      io_ack    <= '0;
      io_q      <= '0;
    end else begin
      io_ack <= '0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            gnt_idx  <= pick_idx;
            io_gnt   <= GNT_ONE << pick_idx;
            lat_wren <= sel_wren;
            lat_addr <= sel_addr;
            lat_data <= sel_data;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (io_owns) begin
            stall_cnt <= '0;
            state     <= RESP;
          end else begin
            stall_cnt <= stall_cnt + 8'd1;
          end
        end
        RESP: begin
          io_ack   <= io_gnt;
          io_q     <= ram_dataOut;
          last_ptr <= gnt_idx;
          io_gnt   <= '0;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter
// Drives the arbiter with directed and random traffic, models the RAM behind
// it, and compares every cycle against a transaction-level reference model.

module tb_dmem_port_arbiter;

  localparam int NREQ = 5;
  localparam int AW   = 12;
  localparam int DW   = 32;
  localparam int MAXS = 8;

  logic               clock;
  logic               reset;
  logic               cpu_req;
  logic               cpu_wren;
  logic [AW-1:0]      cpu_addr;
  logic [DW-1:0]      cpu_data;
  logic [DW-1:0]      cpu_q;
  logic               cpu_stall;
  logic [NREQ-1:0]    io_req;
  logic [NREQ-1:0]    io_wren;
  logic [NREQ*AW-1:0] io_addr;
  logic [NREQ*DW-1:0] io_data;
  logic [NREQ-1:0]    io_gnt;
  logic [NREQ-1:0]    io_ack;
  logic [DW-1:0]      io_q;
  logic               ram_wEn;
  logic [AW-1:0]      ram_addr;
  logic [DW-1:0]      ram_dataIn;
  bit   [DW-1:0]      ram_dataOut;

  bit [DW-1:0] mem    [4096];
  bit [DW-1:0] shadow [4096];

  int checks;
  int passes;

  // reference model state
  int          m_cur;
  int          m_last;
  int          m_lost;
  bit          m_went;
  int          m_ack;
  bit          m_ack_rd;
  bit [DW-1:0] m_ack_q;
  bit [DW-1:0] m_q_cap;
  bit          m_lat_wren;
  bit [AW-1:0] m_lat_addr;
  bit [DW-1:0] m_lat_data;
  bit [DW-1:0] exp_rd;

  // what the DUT showed at the last sampling point
  logic [NREQ-1:0] seen_gnt;
  logic [NREQ-1:0] seen_ack;
  logic            seen_stall;
  logic [DW-1:0]   seen_q;

  dmem_port_arbiter #(
    .NUM_REQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .MAX_STALL(MAXS)
  ) dut (
    .clock(clock),
    .reset(reset),
    .cpu_req(cpu_req),
    .cpu_wren(cpu_wren),
    .cpu_addr(cpu_addr),
    .cpu_data(cpu_data),
    .cpu_q(cpu_q),
    .cpu_stall(cpu_stall),
    .io_req(io_req),
    .io_wren(io_wren),
    .io_addr(io_addr),
    .io_data(io_data),
    .io_gnt(io_gnt),
    .io_ack(io_ack),
    .io_q(io_q),
    .ram_wEn(ram_wEn),
    .ram_addr(ram_addr),
    .ram_dataIn(ram_dataIn),
    .ram_dataOut(ram_dataOut)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous-read RAM with read-before-write on the same edge.
  always @(posedge clock) begin
    if (ram_wEn) mem[ram_addr] <= ram_dataIn;
    ram_dataOut <= mem[ram_addr];
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, actual, expected, $time);
    else
      passes++;
  endtask

  function automatic int oh2i(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic void model_reset();
    m_cur  = -1;
    m_last = NREQ - 1;
    m_lost = 0;
    m_went = 1'b0;
    m_ack  = -1;
  endfunction

  // Compare this cycle's outputs with the model, then advance the model
  // across the coming rising edge.
  task automatic checkCycle();
    logic owns, e_wen, e_stall, found;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
    logic [DW-1:0] nxt;
    logic [NREQ-1:0] e_gnt, e_ack;
    int cnd;
    if (!reset) model_reset();
    seen_gnt   = io_gnt;
    seen_ack   = io_ack;
    seen_stall = cpu_stall;
    seen_q     = io_q;
    owns    = (m_cur >= 0) && !m_went && (!cpu_req || m_lost == MAXS);
    e_stall = (m_cur >= 0) && !m_went && cpu_req && (m_lost == MAXS);
    e_wen   = owns ? m_lat_wren : (cpu_req & cpu_wren);
    e_addr  = owns ? m_lat_addr : cpu_addr;
    e_data  = owns ? m_lat_data : cpu_data;
    e_gnt   = (m_cur >= 0) ? NREQ'(1 << m_cur) : '0;
    e_ack   = (m_ack >= 0) ? NREQ'(1 << m_ack) : '0;
    checkOutput("io_gnt", 64'(io_gnt), 64'(e_gnt));
    checkOutput("io_ack", 64'(io_ack), 64'(e_ack));
    checkOutput("cpu_stall", 64'(cpu_stall), 64'(e_stall));
    checkOutput("ram_wEn", 64'(ram_wEn), 64'(e_wen));
    checkOutput("ram_addr", 64'(ram_addr), 64'(e_addr));
    checkOutput("ram_dataIn", 64'(ram_dataIn), 64'(e_data));
    checkOutput("cpu_q", 64'(cpu_q), 64'(exp_rd));
    if (m_ack >= 0 && m_ack_rd) checkOutput("io_q", 64'(io_q), 64'(m_ack_q));
    nxt = shadow[e_addr];
    if (e_wen) shadow[e_addr] = e_data;
    exp_rd = nxt;
    m_ack = -1;
    if (reset) begin
      if (m_cur < 0) begin
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
          cnd = (m_last + k) % NREQ;
          if (!found && io_req[cnd]) begin
            found      = 1'b1;
            m_cur      = cnd;
            m_went     = 1'b0;
            m_lat_wren = io_wren[cnd];
            m_lat_addr = io_addr[cnd*AW +: AW];
            m_lat_data = io_data[cnd*DW +: DW];
          end
        end
      end else if (!m_went) begin
        if (owns) begin
          m_went  = 1'b1;
          m_lost  = 0;
          m_q_cap = nxt;
        end else begin
          m_lost++;
        end
      end else begin
        m_ack    = m_cur;
        m_ack_rd = !m_lat_wren;
        m_ack_q  = m_q_cap;
        m_last   = m_cur;
        m_cur    = -1;
        m_went   = 1'b0;
      end
    end
  endtask

  // One clock: sample/check at the falling edge, return just after the rise.
  task automatic run_cycle();
    @(negedge clock);
    checkCycle();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic c_req, input logic c_wren, input logic [AW-1:0] c_addr,
                               input logic [DW-1:0] c_data, input logic [NREQ-1:0] r_req);
    cpu_req  = c_req;
    cpu_wren = c_wren;
    cpu_addr = c_addr;
    cpu_data = c_data;
    io_req   = r_req;
  endtask

  task automatic set_io(input int idx, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    io_wren[idx]        = wr;
    io_addr[idx*AW +: AW] = a;
    io_data[idx*DW +: DW] = d;
  endtask

  // One IO access: request, drop after grant, wait (bounded) for the ack.
  task automatic io_access(input int idx, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit done;
    done = 1'b0;
    set_io(idx, wr, a, d);
    io_req[idx] = 1'b1;
    for (int c = 0; c < 40 && !done; c++) begin
      run_cycle();
      if (seen_gnt[idx]) io_req[idx] = 1'b0;
      if (seen_ack[idx]) done = 1'b1;
    end
    io_req[idx] = 1'b0;
    checkOutput("io_access_done", 64'(done), 64'd1);
  endtask

  int grant_seq [6];
  int ack_cyc   [6];
  int ng, na, lost_cnt, stall_cyc, extra_acks, guard, busy_pct;
  logic [NREQ-1:0] prev_gnt;
  bit got_ack;

  initial begin
    checks = 0;
    passes = 0;
    model_reset();
    exp_rd = '0;
    reset = 1'b0;
    io_wren = '0;
    io_addr = '0;
    io_data = '0;
    applyStimulus(1'b0, 1'b0, '0, '0, '0);

    // reset held for two cycles, then idle
    run_cycle();
    run_cycle();
    reset = 1'b1;
    for (int c = 0; c < 3; c++) run_cycle();
    checkOutput("rst_io_q", 64'(io_q), 64'd0);
    checkOutput("rst_io_gnt", 64'(io_gnt), 64'd0);
    checkOutput("rst_stall", 64'(cpu_stall), 64'd0);

    // all requesters high: strict round robin, acks 3 cycles apart
    for (int i = 0; i < 6; i++) begin
      grant_seq[i] = -1;
      ack_cyc[i]   = -100;
    end
    for (int i = 0; i < NREQ; i++) set_io(i, 1'b0, AW'(i), '0);
    io_req = '1;
    ng = 0;
    na = 0;
    prev_gnt = '0;
    for (int c = 0; c < 40 && na < 6; c++) begin
      run_cycle();
      if (seen_gnt != 0 && prev_gnt == 0) begin
        if (ng < 6) grant_seq[ng] = oh2i(seen_gnt);
        ng++;
        if (ng == 6) io_req = '0;
      end
      if (seen_ack != 0) begin
        if (na < 6) ack_cyc[na] = c;
        na++;
      end
      prev_gnt = seen_gnt;
    end
    io_req = '0;
    for (int i = 0; i < 6; i++) checkOutput("rr_order", 64'(grant_seq[i]), 64'(i % NREQ));
    for (int i = 1; i < 6; i++) checkOutput("rr_ack_gap", 64'(ack_cyc[i] - ack_cyc[i-1]), 64'd3);

    // requester 2 writes then reads back
    io_access(2, 1'b1, 12'h010, 32'hDEADBEEF);
    io_access(2, 1'b0, 12'h010, 32'h0);
    checkOutput("io_read_back", 64'(seen_q), 64'hDEADBEEF);

    // CPU busy writing 0x020: requester 0 starves MAX_STALL cycles then forces
    applyStimulus(1'b1, 1'b1, 12'h020, 32'h12345678, 5'b00001);
    set_io(0, 1'b0, 12'h010, '0);
    lost_cnt = 0;
    stall_cyc = 0;
    got_ack = 1'b0;
    for (int c = 0; c < 40 && !got_ack; c++) begin
      run_cycle();
      if (seen_gnt[0]) io_req[0] = 1'b0;
      if (seen_gnt[0] && !seen_stall && stall_cyc == 0) lost_cnt++;
      if (seen_stall) stall_cyc++;
      if (seen_ack[0]) got_ack = 1'b1;
    end
    checkOutput("starve_lost", 64'(lost_cnt), 64'(MAXS));
    checkOutput("starve_stall_cycles", 64'(stall_cyc), 64'd1);
    checkOutput("starve_ack", 64'(got_ack), 64'd1);
    checkOutput("starve_q", 64'(seen_q), 64'hDEADBEEF);
    applyStimulus(1'b0, 1'b0, '0, '0, '0);
    run_cycle();

    // requester 3 drops its request right after the grant: exactly one ack
    io_access(3, 1'b1, 12'h033, 32'hA5A5A5A5);
    extra_acks = 0;
    for (int c = 0; c < 6; c++) begin
      run_cycle();
      if (seen_ack[3]) extra_acks++;
    end
    checkOutput("drop_single_ack", 64'(extra_acks), 64'd0);

    // reset during RESP abandons the access; requester 0 wins afterwards
    set_io(1, 1'b0, 12'h005, '0);
    io_req[1] = 1'b1;
    guard = 0;
    while (!(m_cur >= 0 && m_went) && guard < 20) begin
      run_cycle();
      guard++;
    end
    checkOutput("reach_resp", 64'(guard < 20), 64'd1);
    io_req = '1;
    reset = 1'b0;
    run_cycle();
    checkOutput("rst_mid_ack", 64'(seen_ack), 64'd0);
    checkOutput("rst_mid_gnt", 64'(seen_gnt), 64'd0);
    run_cycle();
    reset = 1'b1;
    run_cycle();
    run_cycle();
    checkOutput("rst_first_gnt", 64'(seen_gnt), 64'b00001);
    io_req = '0;
    for (int c = 0; c < 6; c++) run_cycle();

    // random traffic: heavy CPU load first, then light
    for (int c = 0; c < 600; c++) begin
      busy_pct = (c < 300) ? 85 : 35;
      applyStimulus(($urandom_range(99) < busy_pct), 1'($urandom), AW'($urandom_range(15)),
                    $urandom, NREQ'($urandom));
      for (int i = 0; i < NREQ; i++) set_io(i, 1'($urandom), AW'($urandom_range(15)), $urandom);
      run_cycle();
    end
    applyStimulus(1'b0, 1'b0, '0, '0, '0);
    for (int c = 0; c < 20; c++) run_cycle();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
